// File: rtl/pdm_tx_if.sv
// PCM sample handshake between a sample source and the PDM transmit modulator.
interface pdm_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] sample_i;
  logic             sample_valid_i;
  logic             sample_ready_o;

  modport master (output sample_i, output sample_valid_i, input sample_ready_o);
  modport slave  (input sample_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/pdm_tx_modulator.sv
// First-order sigma-delta PDM transmitter: PCM samples in over valid/ready,
// PDM bitstream out with a divided bit clock and a one-entry sample buffer.
module pdm_tx_modulator #(
  parameter int FREQ_DIV = 32,
  parameter int WIDTH    = 8,
  parameter int OSR      = 128
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     en_i,
  pdm_tx_if.slave  smp,
  output logic     pdm_clk_o,
  output logic     pdm_data_o,
  output logic     underrun_o
);
  localparam int DIV_W = (FREQ_DIV > 2) ? $clog2(FREQ_DIV) : 1;
  localparam int BIT_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FREQ_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(FREQ_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             started_q, started_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic             underrun_q, underrun_d;

  logic             bit_tick;
  logic             boundary;
  logic             transfer;
  logic [WIDTH:0]   sum;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    buf_d      = buf_q;
    started_d  = started_q;

    bit_tick = en_i && (div_cnt_q == DIV_LAST);
    boundary = bit_tick && (bit_cnt_q == BIT_LAST);
    transfer = smp.sample_valid_i && !buf_full_q;
    sum      = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, cur_q};

    if (en_i) begin
      div_cnt_d = bit_tick ? '0 : div_cnt_q + 1'b1;
    end
    // Registered from the next count so the clock edge lines up with the data update.
    pdm_clk_d = (div_cnt_d >= DIV_HALF);

    if (bit_tick) begin
      acc_d     = sum;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (transfer) begin
      buf_d = smp.sample_i;
    end
    if (boundary && buf_full_q) begin
      cur_d = buf_q;
    end
    buf_full_d = transfer || (buf_full_q && !boundary);
    started_d  = started_q || transfer;
    underrun_d = boundary && !buf_full_q && started_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      cur_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      started_q  <= 1'b0;
      pdm_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      started_q  <= started_d;
      pdm_clk_q  <= pdm_clk_d;
      underrun_q <= underrun_d;
    end
  end

  // The accumulator carry is the current PDM bit; idle forces both pins low.
  assign pdm_clk_o          = en_i & pdm_clk_q;
  assign pdm_data_o         = en_i & acc_q[WIDTH];
  assign underrun_o         = underrun_q;
  assign smp.sample_ready_o = ~buf_full_q;
endmodule
